scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
Parametrised, time-multiplexed one-hot select generator that drives the digit commons of the alarm clock's multiplexed 7-segment display.
- A prescaler steps a digit index through 0..N-1 and decodes it to a one-hot select.
- Each digit slot starts with a blanking gap to suppress ghosting.
- Override mode gives direct, combinational-style decoder behaviour for test and setting modes.
- Sits between the display controller (segment data mux keyed on S) and the pad drivers.

Parameters:
- N, 8: number of select outputs / digits; legal range 2..32.
- PRESCALE, 50000: clock cycles per digit slot; must be >= 1.
- BLANK, 2: cycles at the start of each slot with all outputs inactive; must be < PRESCALE.
- ACTIVE_LOW, 0: 1 inverts Y polarity (common-anode drive).
- Derived localparam SEL_W = clog2(N), minimum 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- enable  in  1  active-high block enable
- hold  in  1  freeze scan on current digit
- force_en  in  1  override: select force_sel directly
- force_sel  in  SEL_W  override index
- Y  out  N  one-hot select; polarity per ACTIVE_LOW
- S  out  SEL_W  index of the digit currently scanned, for the segment data mux
- frame_start  out  1  one-cycle pulse at start of each scan frame

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Internal state: prescale counter cnt (0..PRESCALE-1) and digit index idx (0..N-1).
- All outputs are registered. Y, S and frame_start reflect the cnt/idx state of the previous cycle (1-cycle latency).
- Reset (reset_n=0 at a clk edge):
  - cnt=0, idx=0, S=0, frame_start=0.
  - Y all inactive: 0s, or 1s if ACTIVE_LOW.
  - Reset mid-slot aborts the slot immediately.
- Priority, highest first: reset, !enable, force_en, hold, scan.
- enable=0:
  - cnt and idx are cleared to 0; Y is inactive; frame_start=0.
  - On re-enable, the scan restarts at digit 0 with a blanking gap.
- Scan (normal mode):
  - cnt increments each cycle. At cnt=PRESCALE-1 it wraps to 0 and idx increments; idx wraps N-1 -> 0.
  - Y is inactive while cnt < BLANK; otherwise Y = one-hot(idx).
  - S = idx always, including during blanking.
  - frame_start=1 for exactly one cycle whenever the registered state is idx=0, cnt=0. This includes the first slot after reset or re-enable.
- hold=1: cnt and idx freeze; Y, S and frame_start keep their last values (a held frame_start is forced to 0). Releasing hold resumes counting from the frozen state.
- force_en=1:
  - Y = one-hot(force_sel) with no blanking; S = force_sel.
  - force_sel >= N gives Y inactive; S still equals force_sel.
  - cnt and idx keep advancing (hold is still honoured), so releasing force returns to the live scan position.
  - frame_start=0 while forced.
- PRESCALE=1: BLANK must be 0 and idx advances every cycle.
- N not a power of two: idx never takes values >= N.
- Exactly one Y bit is active whenever Y is not inactive.
- Elaboration check: an illegal parameter combination is a fatal error.

Decomposition:
- Shared display package:
  - clog2 function
  - polarity constants ACTIVE_HIGH=0, ACTIVE_LOW=1
  - default PRESCALE values for 1 kHz and 500 Hz digit rates at the board clock
- One sub-module: onehot_decoder, parametrised N.
  - Combinational index-to-one-hot with enable; out-of-range input gives all zeros.
  - Generalises the existing 3-to-8 decoder.
  - Instantiated once; its input is muxed between idx and force_sel.
  - Polarity inversion and output registers live in scan_decoder.

Test Plan:
- N=4, PRESCALE=4, BLANK=1, ACTIVE_LOW=0; release reset -> first visible cycle Y=0000, S=0, frame_start=1. Next 3 cycles Y=0001. Then 0000 and S=1, then three cycles of 0010, and so on through 1000. Frame_start repeats every 16 cycles.
- Same configuration with ACTIVE_LOW=1 -> reset value Y=1111, digit 2 active shows 1011.
- Assert hold mid-way through digit 2 for 10 cycles -> Y=0100 and S=2 stay constant. After release, the remaining slot cycles complete before S=3.
- force_en=1, force_sel=3 during scan -> next cycle Y=1000, S=3, frame_start=0. force_sel=2 -> Y=0100 with no blank. On release, Y and S resume at the live idx, proving the scan kept running.
- N=5, PRESCALE=2, BLANK=0:
  - Scan -> S sequence 0,1,2,3,4,0 with 2 cycles each, never 5..7.
  - force_sel=6 -> Y=00000.
- Drop enable mid-slot on digit 3, then reset_n=0 mid-slot -> Y inactive the next cycle in both cases. Re-enable -> restart at S=0 with blank and a frame_start pulse.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared display definitions: index-width helper, select polarity codes and
// digit-rate prescale defaults for the 50 MHz board clock.
package scan_decoder_pkg;

    localparam int POL_ACTIVE_HIGH = 0;
    localparam int POL_ACTIVE_LOW  = 1;

    localparam int BOARD_CLK_HZ   = 50_000_000;
    localparam int PRESCALE_1KHZ  = BOARD_CLK_HZ / 1000;
    localparam int PRESCALE_500HZ = BOARD_CLK_HZ / 500;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational index-to-one-hot decoder with enable; no latency, no flow control.
// Out-of-range indices decode to all zeros.
module onehot_decoder
    import scan_decoder_pkg::*;
#(
    parameter int N = 8,
    localparam int SEL_W = clog2(N)
) (
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [N-1:0]     y_o
);

    always_comb begin
        y_o = '0;
        for (int i = 0; i < N; i++) begin
            y_o[i] = en_i && (sel_i == SEL_W'(i));
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Time-multiplexed digit-select scanner with per-slot blanking and direct override.
// All outputs registered one cycle after the cnt/idx state they describe.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int N          = 8,
    parameter int PRESCALE   = PRESCALE_1KHZ,
    parameter int BLANK      = 2,
    parameter int ACTIVE_LOW = POL_ACTIVE_HIGH,
    localparam int SEL_W     = clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             hold,
    input  logic             force_en,
    input  logic [SEL_W-1:0] force_sel,
    output logic [N-1:0]     Y,
    output logic [SEL_W-1:0] S,
    output logic             frame_start
);

    localparam int CNT_W = clog2(PRESCALE);
    localparam logic [N-1:0] Y_OFF = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    if (N < 2 || N > 32 || PRESCALE < 1 || BLANK < 0 || BLANK >= PRESCALE ||
        (ACTIVE_LOW != 0 && ACTIVE_LOW != 1)) begin : g_bad_params
        $fatal(1, "scan_decoder: illegal parameter combination");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_adv;
    logic [SEL_W-1:0] idx_q, idx_d, idx_adv;
    logic [N-1:0]     y_q, y_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic             fs_q, fs_d;

    logic             last_cnt;
    logic             dec_en;
    logic [SEL_W-1:0] dec_sel;
    logic [N-1:0]     dec_y;

    assign last_cnt = (cnt_q == CNT_W'(PRESCALE - 1));
    assign cnt_adv  = last_cnt ? '0 : cnt_q + 1'b1;
    assign idx_adv  = !last_cnt ? idx_q :
                      (idx_q == SEL_W'(N - 1)) ? '0 : idx_q + 1'b1;

    // Override bypasses blanking; live scan is dark for the first BLANK cycles of a slot.
    assign dec_sel = force_en ? force_sel : idx_q;
    assign dec_en  = force_en || (int'(cnt_q) >= BLANK);

    onehot_decoder #(.N(N)) u_dec (
        .en_i  (dec_en),
        .sel_i (dec_sel),
        .y_o   (dec_y)
    );

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        y_d   = y_q;
        s_d   = s_q;
        fs_d  = 1'b0;
        if (!enable) begin
            cnt_d = '0;
            idx_d = '0;
            y_d   = Y_OFF;
            s_d   = '0;
        end else if (force_en) begin
            if (!hold) begin
                cnt_d = cnt_adv;
                idx_d = idx_adv;
            end
            y_d = dec_y ^ Y_OFF;
            s_d = force_sel;
        end else if (!hold) begin
            cnt_d = cnt_adv;
            idx_d = idx_adv;
            y_d   = dec_y ^ Y_OFF;
            s_d   = idx_q;
            fs_d  = (cnt_q == '0) && (idx_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            y_q   <= Y_OFF;
            s_q   <= '0;
            fs_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            y_q   <= y_d;
            s_q   <= s_d;
            fs_q  <= fs_d;
        end
    end

    assign Y           = y_q;
    assign S           = s_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Three scanner configurations driven in lockstep and checked every cycle
// against a time-based model of the digit scan.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n, en, hold, frc;
    logic [2:0] fsel;

    logic [3:0] ya, yb;
    logic [4:0] yc;
    logic [1:0] sa, sb;
    logic [2:0] sc;
    logic       fa, fb, fc;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scan_decoder #(.N(4), .PRESCALE(4), .BLANK(1), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .reset_n(rst_n), .enable(en), .hold(hold), .force_en(frc),
        .force_sel(fsel[1:0]), .Y(ya), .S(sa), .frame_start(fa));

    scan_decoder #(.N(4), .PRESCALE(4), .BLANK(1), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .reset_n(rst_n), .enable(en), .hold(hold), .force_en(frc),
        .force_sel(fsel[1:0]), .Y(yb), .S(sb), .frame_start(fb));

    scan_decoder #(.N(5), .PRESCALE(2), .BLANK(0), .ACTIVE_LOW(0)) dut_c (
        .clk(clk), .reset_n(rst_n), .enable(en), .hold(hold), .force_en(frc),
        .force_sel(fsel), .Y(yc), .S(sc), .frame_start(fc));

    // Model: t counts scanning cycles since restart; slot, digit and phase follow by division.
    int Np [3] = '{4, 4, 5};
    int Pp [3] = '{4, 4, 2};
    int Bp [3] = '{1, 1, 0};
    int ALp[3] = '{0, 1, 0};
    int t  [3];
    logic [31:0] eY[3];
    logic [31:0] eS[3];
    logic        eF[3];

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            int n, p, b, sel, idx;
            logic [31:0] off;
            n   = Np[k];
            p   = Pp[k];
            b   = Bp[k];
            off = (ALp[k] != 0) ? ((32'd1 << n) - 32'd1) : 32'd0;
            sel = (k == 2) ? int'(fsel) : int'(fsel[1:0]);
            if (!rst_n || !en) begin
                t[k] = 0; eY[k] = off; eS[k] = 0; eF[k] = 1'b0;
            end else if (frc) begin
                eY[k] = ((sel < n) ? (32'd1 << sel) : 32'd0) ^ off;
                eS[k] = sel;
                eF[k] = 1'b0;
                if (!hold) t[k] = t[k] + 1;
            end else if (hold) begin
                eF[k] = 1'b0;
            end else begin
                idx   = (t[k] / p) % n;
                eY[k] = (((t[k] % p) < b) ? 32'd0 : (32'd1 << idx)) ^ off;
                eS[k] = idx;
                eF[k] = ((t[k] % (p * n)) == 0);
                t[k]  = t[k] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("A.Y", 32'(ya), eY[0]); chk("A.S", 32'(sa), eS[0]); chk("A.fs", 32'(fa), 32'(eF[0]));
        chk("B.Y", 32'(yb), eY[1]); chk("B.S", 32'(sb), eS[1]); chk("B.fs", 32'(fb), 32'(eF[1]));
        chk("C.Y", 32'(yc), eY[2]); chk("C.S", 32'(sc), eS[2]); chk("C.fs", 32'(fc), 32'(eF[2]));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; hold = 1'b0; frc = 1'b0; fsel = 3'd0;
        run(2);
        rst_n = 1'b1;
        run(42);                 // two full frames of the N=4 units, now mid digit 2
        hold = 1'b1;  run(10);
        hold = 1'b0;  run(5);
        frc = 1'b1; fsel = 3'd3; run(3);
        fsel = 3'd2;  run(3);
        fsel = 3'd6;  run(2);
        hold = 1'b1;  run(3);
        hold = 1'b0;  frc = 1'b0; run(6);
        run(7);
        en = 1'b0;    run(2);
        en = 1'b1;    run(14);
        rst_n = 1'b0; run(1);
        rst_n = 1'b1; run(20);
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            en    = ($urandom_range(0, 29) != 0);
            hold  = ($urandom_range(0, 7) == 0);
            frc   = ($urandom_range(0, 9) == 0);
            fsel  = 3'($urandom_range(0, 7));
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
